ex_stage: RTL and testbench

EX_STAGE -- requirements
Module: ex_stage

---
 rtl/ex_stage.sv | 192 +++++++++++++++++++
 tb/tb_ex_stage.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU with signed-overflow detection and an
// iterative unsigned shift-add multiplier. A multiply holds the stage busy
// until its product is ready. Stall freezes the stage. Flush discards the
// current result and any multiply in flight.
module ex_stage #(
    parameter int DATA_W     = 32,
    parameter int MUL_CYCLES = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic              id_en,
    input  logic [3:0]        id_alu_op,
    input  logic [DATA_W-1:0] id_alu_in_0,
    input  logic [DATA_W-1:0] id_alu_in_1,
    input  logic [4:0]        id_dst_addr,
    input  logic              id_gpr_we,
    output logic              ex_en,
    output logic [DATA_W-1:0] ex_alu_out,
    output logic [4:0]        ex_dst_addr,
    output logic              ex_gpr_we,
    output logic [1:0]        ex_exp_code,
    output logic              busy
);

    localparam int CNT_W = $clog2(MUL_CYCLES + 1);

    localparam logic [3:0] OP_AND  = 4'd1;
    localparam logic [3:0] OP_OR   = 4'd2;
    localparam logic [3:0] OP_XOR  = 4'd3;
    localparam logic [3:0] OP_ADDS = 4'd4;
    localparam logic [3:0] OP_ADDU = 4'd5;
    localparam logic [3:0] OP_SUBS = 4'd6;
    localparam logic [3:0] OP_SUBU = 4'd7;
    localparam logic [3:0] OP_SHRL = 4'd8;
    localparam logic [3:0] OP_SHLL = 4'd9;
    localparam logic [3:0] OP_MUL  = 4'd10;

    localparam logic [1:0] EXP_NONE = 2'b00;
    localparam logic [1:0] EXP_OVF  = 2'b01;

    typedef enum logic {
        IDLE,
        MUL
    } state_t;

    state_t            state_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [DATA_W-1:0] mcand_reg;
    logic [DATA_W-1:0] mplier_reg;
    logic [DATA_W-1:0] acc_reg;
    logic              mul_we_reg;

    logic              ex_en_reg;
    logic [DATA_W-1:0] ex_alu_out_reg;
    logic [4:0]        ex_dst_addr_reg;
    logic              ex_gpr_we_reg;
    logic [1:0]        ex_exp_code_reg;
    logic              busy_reg;

    logic [DATA_W-1:0] sum;
    logic [DATA_W-1:0] diff;
    logic [4:0]        shamt;
    logic [DATA_W-1:0] alu_result;
    logic              alu_ovf;
    logic              is_mul;
    logic              is_nop;
    logic [DATA_W-1:0] acc_next;
    logic              mul_last;

    // Single-cycle ALU decode with signed-overflow detection
    always_comb begin
        sum        = id_alu_in_0 + id_alu_in_1;
        diff       = id_alu_in_0 - id_alu_in_1;
        shamt      = id_alu_in_1[4:0];
        alu_result = '0;
        alu_ovf    = 1'b0;
        is_mul     = 1'b0;
        is_nop     = 1'b0;
        case (id_alu_op)
            OP_AND:  alu_result = id_alu_in_0 & id_alu_in_1;
            OP_OR:   alu_result = id_alu_in_0 | id_alu_in_1;
            OP_XOR:  alu_result = id_alu_in_0 ^ id_alu_in_1;
            OP_ADDS: begin
                alu_result = sum;
                alu_ovf    = (id_alu_in_0[DATA_W-1] == id_alu_in_1[DATA_W-1]) &&
                             (sum[DATA_W-1] != id_alu_in_0[DATA_W-1]);
            end
            OP_ADDU: alu_result = sum;
            OP_SUBS: begin
                alu_result = diff;
                alu_ovf    = (id_alu_in_0[DATA_W-1] != id_alu_in_1[DATA_W-1]) &&
                             (diff[DATA_W-1] != id_alu_in_0[DATA_W-1]);
            end
            OP_SUBU: alu_result = diff;
            OP_SHRL: alu_result = id_alu_in_0 >> shamt;
            OP_SHLL: alu_result = id_alu_in_0 << shamt;
            OP_MUL:  is_mul = 1'b1;
            default: is_nop = 1'b1;
        endcase
    end

    // One shift-add step: add the multiplicand when the current multiplier bit is set
    always_comb begin
        acc_next = acc_reg + (mplier_reg[0] ? mcand_reg : '0);
        mul_last = (cnt_reg == CNT_W'(MUL_CYCLES - 1));
    end

    // Stage FSM, multiplier iteration and EX/MEM output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg       <= IDLE;
            cnt_reg         <= '0;
            mcand_reg       <= '0;
            mplier_reg      <= '0;
            acc_reg         <= '0;
            mul_we_reg      <= 1'b0;
            ex_en_reg       <= 1'b0;
            ex_alu_out_reg  <= '0;
            ex_dst_addr_reg <= '0;
            ex_gpr_we_reg   <= 1'b0;
            ex_exp_code_reg <= EXP_NONE;
            busy_reg        <= 1'b0;
        end else if (flush) begin
            state_reg       <= IDLE;
            cnt_reg         <= '0;
            ex_en_reg       <= 1'b0;
            ex_gpr_we_reg   <= 1'b0;
            ex_exp_code_reg <= EXP_NONE;
            busy_reg        <= 1'b0;
        end else if (!stall) begin
            case (state_reg)
                IDLE: begin
                    if (id_en && is_mul) begin
                        // Capture operands; the result stays invalid until the product is done
                        mcand_reg       <= id_alu_in_0;
                        mplier_reg      <= id_alu_in_1;
                        acc_reg         <= '0;
                        cnt_reg         <= '0;
                        mul_we_reg      <= id_gpr_we;
                        ex_dst_addr_reg <= id_dst_addr;
                        ex_en_reg       <= 1'b0;
                        ex_gpr_we_reg   <= 1'b0;
                        ex_exp_code_reg <= EXP_NONE;
                        busy_reg        <= 1'b1;
                        state_reg       <= MUL;
                    end else if (id_en && !is_nop) begin
                        ex_dst_addr_reg <= id_dst_addr;
                        ex_alu_out_reg  <= alu_result;
                        ex_en_reg       <= 1'b1;
                        ex_gpr_we_reg   <= id_gpr_we & ~alu_ovf;
                        ex_exp_code_reg <= alu_ovf ? EXP_OVF : EXP_NONE;
                    end else begin
                        // Bubble; a valid NOP still produces a zero result
                        if (id_en) begin
                            ex_dst_addr_reg <= id_dst_addr;
                            ex_alu_out_reg  <= '0;
                        end
                        ex_en_reg       <= 1'b0;
                        ex_gpr_we_reg   <= 1'b0;
                        ex_exp_code_reg <= EXP_NONE;
                    end
                end
                MUL: begin
                    acc_reg    <= acc_next;
                    mcand_reg  <= mcand_reg << 1;
                    mplier_reg <= mplier_reg >> 1;
                    cnt_reg    <= cnt_reg + 1'b1;
                    if (mul_last) begin
                        ex_alu_out_reg  <= acc_next;
                        ex_en_reg       <= 1'b1;
                        ex_gpr_we_reg   <= mul_we_reg;
                        ex_exp_code_reg <= EXP_NONE;
                        busy_reg        <= 1'b0;
                        cnt_reg         <= '0;
                        state_reg       <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign ex_en       = ex_en_reg;
    assign ex_alu_out  = ex_alu_out_reg;
    assign ex_dst_addr = ex_dst_addr_reg;
    assign ex_gpr_we   = ex_gpr_we_reg;
    assign ex_exp_code = ex_exp_code_reg;
    assign busy        = busy_reg;

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: a table of single-cycle ALU vectors followed
// by hand-written multiply, stall, flush and asynchronous-reset sequences.
module tb_ex_stage;

    localparam int DW = 32;

    logic          clk;
    logic          reset;
    logic          stall;
    logic          flush;
    logic          id_en;
    logic [3:0]    id_alu_op;
    logic [DW-1:0] id_alu_in_0;
    logic [DW-1:0] id_alu_in_1;
    logic [4:0]    id_dst_addr;
    logic          id_gpr_we;
    logic          ex_en;
    logic [DW-1:0] ex_alu_out;
    logic [4:0]    ex_dst_addr;
    logic          ex_gpr_we;
    logic [1:0]    ex_exp_code;
    logic          busy;

    int tests_run;
    int tests_failed;

    ex_stage #(.DATA_W(DW), .MUL_CYCLES(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .flush       (flush),
        .id_en       (id_en),
        .id_alu_op   (id_alu_op),
        .id_alu_in_0 (id_alu_in_0),
        .id_alu_in_1 (id_alu_in_1),
        .id_dst_addr (id_dst_addr),
        .id_gpr_we   (id_gpr_we),
        .ex_en       (ex_en),
        .ex_alu_out  (ex_alu_out),
        .ex_dst_addr (ex_dst_addr),
        .ex_gpr_we   (ex_gpr_we),
        .ex_exp_code (ex_exp_code),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  dst;
        logic        we;
        logic [31:0] x_out;
        logic [1:0]  x_exp;
        logic        x_we;
        logic        x_en;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic en, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] dst, input logic we);
        id_en       = en;
        id_alu_op   = op;
        id_alu_in_0 = a;
        id_alu_in_1 = b;
        id_dst_addr = dst;
        id_gpr_we   = we;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs a MUL from IDLE; optional stall window; returns busy-cycle count and
    // whether ex_en was ever seen high while busy.
    task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input logic [4:0] dst,
                           input int stall_at, input int stall_len,
                           output int busy_cycles, output logic en_seen);
        @(negedge clk);
        drive(1'b1, 4'd10, a, b, dst, 1'b1);
        tick();
        check("mul_dst", {27'd0, ex_dst_addr}, {27'd0, dst});
        // Different instruction on ID while busy: must be ignored
        @(negedge clk);
        drive(1'b1, 4'd5, 32'h1111_1111, 32'h2222_2222, 5'd30, 1'b1);
        busy_cycles = 0;
        en_seen     = 1'b0;
        while (busy && busy_cycles < 200) begin
            busy_cycles++;
            if (ex_en) en_seen = 1'b1;
            if (busy_cycles == stall_at) begin
                @(negedge clk);
                stall = 1'b1;
            end
            if (busy_cycles == stall_at + stall_len) begin
                @(negedge clk);
                stall = 1'b0;
            end
            tick();
        end
        // Drop the ID instruction before the next accepting edge
        @(negedge clk);
        id_en = 1'b0;
    endtask

    int          cyc;
    logic        en_seen;
    logic [31:0] held_out;

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b0;
        stall        = 1'b0;
        flush        = 1'b0;
        drive(1'b0, 4'd0, 32'd0, 32'd0, 5'd0, 1'b0);

        //                op     a             b             dst  we  out           exp    we    en
        vecs[0]  = '{4'd1,  32'hFFFF_0000, 32'h0F0F_0F0F, 5'd1, 1'b1, 32'h0F0F_0000, 2'b00, 1'b1, 1'b1};
        vecs[1]  = '{4'd2,  32'h0000_00F0, 32'h0000_000F, 5'd2, 1'b1, 32'h0000_00FF, 2'b00, 1'b1, 1'b1};
        vecs[2]  = '{4'd3,  32'hAAAA_5555, 32'hFFFF_0000, 5'd3, 1'b1, 32'h5555_5555, 2'b00, 1'b1, 1'b1};
        vecs[3]  = '{4'd4,  32'h7FFF_FFFF, 32'h0000_0001, 5'd4, 1'b1, 32'h8000_0000, 2'b01, 1'b0, 1'b1};
        vecs[4]  = '{4'd4,  32'h0000_0005, 32'h0000_0003, 5'd5, 1'b1, 32'h0000_0008, 2'b00, 1'b1, 1'b1};
        vecs[5]  = '{4'd4,  32'h8000_0000, 32'h8000_0000, 5'd6, 1'b1, 32'h0000_0000, 2'b01, 1'b0, 1'b1};
        vecs[6]  = '{4'd5,  32'hFFFF_FFFF, 32'h0000_0002, 5'd7, 1'b1, 32'h0000_0001, 2'b00, 1'b1, 1'b1};
        vecs[7]  = '{4'd6,  32'h8000_0000, 32'h0000_0001, 5'd8, 1'b1, 32'h7FFF_FFFF, 2'b01, 1'b0, 1'b1};
        vecs[8]  = '{4'd6,  32'h0000_0000, 32'h8000_0000, 5'd9, 1'b1, 32'h8000_0000, 2'b01, 1'b0, 1'b1};
        vecs[9]  = '{4'd7,  32'h0000_0000, 32'h8000_0000, 5'd10, 1'b1, 32'h8000_0000, 2'b00, 1'b1, 1'b1};
        vecs[10] = '{4'd6,  32'h0000_0005, 32'h0000_0007, 5'd11, 1'b1, 32'hFFFF_FFFE, 2'b00, 1'b1, 1'b1};
        vecs[11] = '{4'd8,  32'h8000_0000, 32'h0000_0004, 5'd12, 1'b1, 32'h0800_0000, 2'b00, 1'b1, 1'b1};
        vecs[12] = '{4'd9,  32'h0000_0001, 32'h0000_001F, 5'd13, 1'b1, 32'h8000_0000, 2'b00, 1'b1, 1'b1};
        vecs[13] = '{4'd9,  32'h0000_0003, 32'h0000_0021, 5'd14, 1'b1, 32'h0000_0006, 2'b00, 1'b1, 1'b1};
        vecs[14] = '{4'd0,  32'h1234_5678, 32'h0000_0001, 5'd15, 1'b1, 32'h0000_0000, 2'b00, 1'b0, 1'b0};
        vecs[15] = '{4'd5,  32'h0000_0010, 32'h0000_0020, 5'd16, 1'b0, 32'h0000_0030, 2'b00, 1'b0, 1'b1};
        vecs[16] = '{4'd12, 32'hDEAD_BEEF, 32'h0000_0001, 5'd17, 1'b1, 32'h0000_0000, 2'b00, 1'b0, 1'b0};
        vecs[17] = '{4'd8,  32'hF000_000F, 32'hFFFF_FFE1, 5'd18, 1'b1, 32'h7800_0007, 2'b00, 1'b1, 1'b1};

        // Reset state
        #12;
        check("rst_en",   {31'd0, ex_en},     32'd0);
        check("rst_out",  ex_alu_out,         32'd0);
        check("rst_dst",  {27'd0, ex_dst_addr}, 32'd0);
        check("rst_we",   {31'd0, ex_gpr_we}, 32'd0);
        check("rst_exp",  {30'd0, ex_exp_code}, 32'd0);
        check("rst_busy", {31'd0, busy},      32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Table-driven single-cycle operations
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(1'b1, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].dst, vecs[i].we);
            tick();
            $display("[TB] vec %0d op=%0d a=0x%08h b=0x%08h -> out=0x%08h exp=%0d we=%0d en=%0d",
                     i, vecs[i].op, vecs[i].a, vecs[i].b, ex_alu_out, ex_exp_code, ex_gpr_we, ex_en);
            check($sformatf("v%0d_out", i), ex_alu_out, vecs[i].x_out);
            check($sformatf("v%0d_exp", i), {30'd0, ex_exp_code}, {30'd0, vecs[i].x_exp});
            check($sformatf("v%0d_we", i),  {31'd0, ex_gpr_we}, {31'd0, vecs[i].x_we});
            check($sformatf("v%0d_en", i),  {31'd0, ex_en}, {31'd0, vecs[i].x_en});
            check($sformatf("v%0d_dst", i), {27'd0, ex_dst_addr}, {27'd0, vecs[i].dst});
        end

        // id_en low gives a bubble
        @(negedge clk);
        drive(1'b1, 4'd2, 32'h0000_0F00, 32'h0000_00F0, 5'd20, 1'b1);
        tick();
        @(negedge clk);
        id_en = 1'b0;
        tick();
        $display("[TB] bubble -> en=%0d we=%0d", ex_en, ex_gpr_we);
        check("bubble_en", {31'd0, ex_en}, 32'd0);
        check("bubble_we", {31'd0, ex_gpr_we}, 32'd0);

        // Stall in IDLE holds outputs
        @(negedge clk);
        drive(1'b1, 4'd5, 32'd100, 32'd23, 5'd21, 1'b1);
        tick();
        @(negedge clk);
        stall = 1'b1;
        drive(1'b1, 4'd5, 32'd1, 32'd1, 5'd22, 1'b1);
        tick();
        tick();
        $display("[TB] idle stall -> out=0x%08h dst=%0d en=%0d", ex_alu_out, ex_dst_addr, ex_en);
        check("istall_out", ex_alu_out, 32'd123);
        check("istall_dst", {27'd0, ex_dst_addr}, 32'd21);
        check("istall_en",  {31'd0, ex_en}, 32'd1);
        @(negedge clk);
        stall = 1'b0;
        id_en = 1'b0;
        tick();

        // MUL 0x00010003 * 5
        run_mul(32'h0001_0003, 32'h0000_0005, 5'd25, -10, 0, cyc, en_seen);
        $display("[TB] mul -> busy_cycles=%0d out=0x%08h en=%0d dst=%0d", cyc, ex_alu_out, ex_en, ex_dst_addr);
        check("mul_busy_cycles", cyc, 32'd32);
        check("mul_en_while_busy", {31'd0, en_seen}, 32'd0);
        check("mul_out", ex_alu_out, 32'h0005_000F);
        check("mul_en",  {31'd0, ex_en}, 32'd1);
        check("mul_we",  {31'd0, ex_gpr_we}, 32'd1);
        check("mul_exp", {30'd0, ex_exp_code}, 32'd0);
        check("mul_dst_done", {27'd0, ex_dst_addr}, 32'd25);
        tick();
        check("mul_en_1cyc", {31'd0, ex_en}, 32'd0);

        // MUL with a 5-cycle stall mid-run
        run_mul(32'h0001_0003, 32'h0000_0005, 5'd26, 10, 5, cyc, en_seen);
        $display("[TB] mul+stall -> busy_cycles=%0d out=0x%08h en=%0d", cyc, ex_alu_out, ex_en);
        check("mstall_busy_cycles", cyc, 32'd37);
        check("mstall_en_while_busy", {31'd0, en_seen}, 32'd0);
        check("mstall_out", ex_alu_out, 32'h0005_000F);
        check("mstall_en",  {31'd0, ex_en}, 32'd1);
        tick();

        // Flush together with stall during MUL aborts it
        @(negedge clk);
        drive(1'b1, 4'd10, 32'h0000_0007, 32'h0000_0009, 5'd27, 1'b1);
        tick();
        id_en = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        @(negedge clk);
        flush = 1'b1;
        stall = 1'b1;
        tick();
        $display("[TB] flush+stall in mul -> busy=%0d en=%0d", busy, ex_en);
        check("flush_busy", {31'd0, busy}, 32'd0);
        check("flush_en",   {31'd0, ex_en}, 32'd0);
        check("flush_we",   {31'd0, ex_gpr_we}, 32'd0);
        @(negedge clk);
        flush = 1'b0;
        stall = 1'b0;
        en_seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (ex_en || busy) en_seen = 1'b1;
        end
        check("flush_no_result", {31'd0, en_seen}, 32'd0);

        // Asynchronous reset at MUL iteration 10
        held_out = ex_alu_out;
        check("pre_rst_out_nonzero", {31'd0, (held_out != 32'd0)}, 32'd1);
        @(negedge clk);
        drive(1'b1, 4'd10, 32'h0000_0003, 32'h0000_0004, 5'd28, 1'b1);
        tick();
        id_en = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        #2;
        reset = 1'b0;
        #1;
        $display("[TB] async reset in mul -> en=%0d out=0x%08h dst=%0d busy=%0d", ex_en, ex_alu_out, ex_dst_addr, busy);
        check("arst_en",   {31'd0, ex_en}, 32'd0);
        check("arst_out",  ex_alu_out, 32'd0);
        check("arst_dst",  {27'd0, ex_dst_addr}, 32'd0);
        check("arst_we",   {31'd0, ex_gpr_we}, 32'd0);
        check("arst_exp",  {30'd0, ex_exp_code}, 32'd0);
        check("arst_busy", {31'd0, busy}, 32'd0);
        #3;
        reset = 1'b1;
        en_seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (ex_en || busy) en_seen = 1'b1;
        end
        check("arst_no_result", {31'd0, en_seen}, 32'd0);
        @(negedge clk);
        drive(1'b1, 4'd9, 32'h0000_0001, 32'd31, 5'd29, 1'b1);
        tick();
        id_en = 1'b0;
        $display("[TB] SHLL after reset -> out=0x%08h en=%0d", ex_alu_out, ex_en);
        check("post_rst_shll_out", ex_alu_out, 32'h8000_0000);
        check("post_rst_shll_en",  {31'd0, ex_en}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Global time limit so the run always terminates
    initial begin
        #200000;
        $display("FAIL timeout: got no completion expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
